zap_ram_ben_arbiter: RTL and testbench

Two-requester arbiter and sequencer for one `zap_ram_simple_ben` instance (3-cycle read latency, separate read and write ports, byte-wise hazard forwarding). After reset it zero-fills the RAM. It then grants requests using fixed-latency tag tracking and returns read data to the requester that issued the read. A read from one requester and a write from the other are dual-issued in the same cycle. Same-kind conflicts are resolved round-robin.

---
 rtl/zap_ram_ben_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_zap_ram_ben_arbiter.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zap_ram_ben_arbiter.sv
// ---------------------------------------------------------------------------
// zap_ram_ben_arbiter
//
// Two-requester arbiter/sequencer in front of one zap_ram_simple_ben
// (3-cycle read latency, separate read/write ports, byte-wise forwarding
// inside the RAM). After reset it zero-fills every RAM word, then grants
// requests: a read from one side and a write from the other dual-issue in
// the same cycle; same-kind conflicts are resolved round-robin. Read data is
// routed back to the issuer with a fixed-latency tag pipeline.
//
// Ports:
//   i_clk, i_reset            clock, asynchronous active-high reset
//   i_stall                   global freeze (RAM clock enable low)
//   i_req_N/i_ben_N/i_addr_N/i_wdata_N
//                             request N; i_ben_N == 0 means read
//   o_ack_N                   combinational accept for request N
//   o_rvalid_N/o_rdata_N      one-cycle read return to requester N
//   o_init_done               high once the zero-fill has completed
//   o_ram_*                   RAM control/write/read-address outputs
//   i_ram_rd_data             RAM read data (3-cycle pipeline output)
// ---------------------------------------------------------------------------
module zap_ram_ben_arbiter #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    localparam int NB = WIDTH / 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_stall,
    input  logic          i_req_0,
    input  logic [NB-1:0] i_ben_0,
    input  logic [AW-1:0] i_addr_0,
    input  logic [WIDTH-1:0] i_wdata_0,
    input  logic          i_req_1,
    input  logic [NB-1:0] i_ben_1,
    input  logic [AW-1:0] i_addr_1,
    input  logic [WIDTH-1:0] i_wdata_1,
    output logic          o_ack_0,
    output logic          o_ack_1,
    output logic          o_rvalid_0,
    output logic          o_rvalid_1,
    output logic [WIDTH-1:0] o_rdata_0,
    output logic [WIDTH-1:0] o_rdata_1,
    output logic          o_init_done,
    output logic          o_ram_clken,
    output logic [NB-1:0] o_ram_wr_en,
    output logic [AW-1:0] o_ram_wr_addr,
    output logic [AW-1:0] o_ram_rd_addr,
    output logic [WIDTH-1:0] o_ram_wr_data,
    input  logic [WIDTH-1:0] i_ram_rd_data
);

    typedef enum logic {StInit, StRun} state_t;

    localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

    state_t        r_state, w_state_d;
    logic [AW-1:0] r_init_addr, w_init_addr_d;
    logic          r_rr, w_rr_d;
    logic          r_init_done, w_init_done_d;

    // Tag pipeline mirrors the RAM read pipeline: stage 0, stage 1, then rvalid.
    logic          r_tag_v0, r_tag_v1;
    logic          r_tag_id0, r_tag_id1;
    logic          r_rvalid_0, r_rvalid_1;

    logic          w_is_rd_0, w_is_rd_1;
    logic          w_gnt_0, w_gnt_1;
    logic          w_rd_issue, w_rd_id;

    assign w_is_rd_0 = (i_ben_0 == '0);
    assign w_is_rd_1 = (i_ben_1 == '0);

    // Grant logic: a read/write pair dual-issues; same-kind pairs use rr.
    always_comb begin
        w_gnt_0 = 1'b0;
        w_gnt_1 = 1'b0;
        w_rr_d  = r_rr;
        if (r_state == StRun && !i_stall) begin
            if (i_req_0 && i_req_1) begin
                if (w_is_rd_0 != w_is_rd_1) begin
                    w_gnt_0 = 1'b1;
                    w_gnt_1 = 1'b1;
                end else begin
                    w_gnt_0 = !r_rr;
                    w_gnt_1 = r_rr;
                    w_rr_d  = !r_rr;
                end
            end else begin
                w_gnt_0 = i_req_0;
                w_gnt_1 = i_req_1;
            end
        end
    end

    // Next state and RAM port steering.
    always_comb begin
        w_state_d     = r_state;
        w_init_addr_d = r_init_addr;
        w_init_done_d = r_init_done;
        o_ram_wr_en   = '0;
        o_ram_wr_addr = '0;
        o_ram_wr_data = '0;
        o_ram_rd_addr = '0;
        w_rd_issue    = 1'b0;
        w_rd_id       = 1'b0;
        unique case (r_state)
            StInit: begin
                if (!i_stall) begin
                    o_ram_wr_en   = '1;
                    o_ram_wr_addr = r_init_addr;
                    if (r_init_addr == LastAddr) begin
                        w_state_d     = StRun;
                        w_init_done_d = 1'b1;
                    end else begin
                        w_init_addr_d = r_init_addr + AW'(1);
                    end
                end
            end
            StRun: begin
                if (w_gnt_0 && !w_is_rd_0) begin
                    o_ram_wr_en   = i_ben_0;
                    o_ram_wr_addr = i_addr_0;
                    o_ram_wr_data = i_wdata_0;
                end else if (w_gnt_1 && !w_is_rd_1) begin
                    o_ram_wr_en   = i_ben_1;
                    o_ram_wr_addr = i_addr_1;
                    o_ram_wr_data = i_wdata_1;
                end
                if (w_gnt_0 && w_is_rd_0) begin
                    o_ram_rd_addr = i_addr_0;
                    w_rd_issue    = 1'b1;
                    w_rd_id       = 1'b0;
                end else if (w_gnt_1 && w_is_rd_1) begin
                    o_ram_rd_addr = i_addr_1;
                    w_rd_issue    = 1'b1;
                    w_rd_id       = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= StInit;
            r_init_addr <= '0;
            r_rr        <= 1'b0;
            r_init_done <= 1'b0;
            r_tag_v0    <= 1'b0;
            r_tag_v1    <= 1'b0;
            r_tag_id0   <= 1'b0;
            r_tag_id1   <= 1'b0;
            r_rvalid_0  <= 1'b0;
            r_rvalid_1  <= 1'b0;
        end else begin
            // Next-state logic already holds these while stalled.
            r_state     <= w_state_d;
            r_init_addr <= w_init_addr_d;
            r_rr        <= w_rr_d;
            r_init_done <= w_init_done_d;
            if (!i_stall) begin
                r_tag_v0   <= w_rd_issue;
                r_tag_id0  <= w_rd_id;
                r_tag_v1   <= r_tag_v0;
                r_tag_id1  <= r_tag_id0;
                r_rvalid_0 <= r_tag_v1 && !r_tag_id1;
                r_rvalid_1 <= r_tag_v1 && r_tag_id1;
            end else begin
                // Pulse must not stretch across a stall: each read returns once.
                r_rvalid_0 <= 1'b0;
                r_rvalid_1 <= 1'b0;
            end
        end
    end

    assign o_ack_0     = w_gnt_0;
    assign o_ack_1     = w_gnt_1;
    assign o_rvalid_0  = r_rvalid_0;
    assign o_rvalid_1  = r_rvalid_1;
    assign o_rdata_0   = i_ram_rd_data;
    assign o_rdata_1   = i_ram_rd_data;
    assign o_init_done = r_init_done;
    assign o_ram_clken = !i_stall;

endmodule

// File: tb/tb_zap_ram_ben_arbiter.sv
// ---------------------------------------------------------------------------
// tb_zap_ram_ben_arbiter
//
// Self-checking bench: a behavioural RAM (3-cycle read, byte forwarding) is
// attached to the RAM ports, and a transaction-level reference model tracks
// memory contents, round-robin pointer and outstanding reads as counts of
// remaining clock-enabled edges.
// ---------------------------------------------------------------------------
module tb_zap_ram_ben_arbiter;
    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int NB    = WIDTH / 8;
    localparam int AW    = $clog2(DEPTH);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, stall;
    logic req_0, req_1;
    logic [NB-1:0] ben_0, ben_1;
    logic [AW-1:0] addr_0, addr_1;
    logic [WIDTH-1:0] wdata_0, wdata_1;
    logic ack_0, ack_1, rvalid_0, rvalid_1, init_done;
    logic [WIDTH-1:0] rdata_0, rdata_1;
    logic ram_clken;
    logic [NB-1:0] ram_wr_en;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr;
    logic [WIDTH-1:0] ram_wr_data, ram_rd_data;

    zap_ram_ben_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_reset(rst), .i_stall(stall),
        .i_req_0(req_0), .i_ben_0(ben_0), .i_addr_0(addr_0), .i_wdata_0(wdata_0),
        .i_req_1(req_1), .i_ben_1(ben_1), .i_addr_1(addr_1), .i_wdata_1(wdata_1),
        .o_ack_0(ack_0), .o_ack_1(ack_1), .o_rvalid_0(rvalid_0), .o_rvalid_1(rvalid_1),
        .o_rdata_0(rdata_0), .o_rdata_1(rdata_1), .o_init_done(init_done),
        .o_ram_clken(ram_clken), .o_ram_wr_en(ram_wr_en), .o_ram_wr_addr(ram_wr_addr),
        .o_ram_rd_addr(ram_rd_addr), .o_ram_wr_data(ram_wr_data),
        .i_ram_rd_data(ram_rd_data)
    );

    // Behavioural RAM: 3-stage read pipeline, new bytes forwarded on same-address write.
    logic [WIDTH-1:0] ram [DEPTH];
    logic [WIDTH-1:0] ram_fwd, ram_s1, ram_s2, ram_s3;
    always_comb begin
        ram_fwd = ram[ram_rd_addr];
        for (int b = 0; b < NB; b++)
            if (ram_wr_en[b] && ram_wr_addr == ram_rd_addr) ram_fwd[b*8 +: 8] = ram_wr_data[b*8 +: 8];
    end
    always @(posedge clk) begin
        if (ram_clken) begin
            for (int b = 0; b < NB; b++)
                if (ram_wr_en[b]) ram[ram_wr_addr][b*8 +: 8] <= ram_wr_data[b*8 +: 8];
            ram_s1 <= ram_fwd;
            ram_s2 <= ram_s1;
            ram_s3 <= ram_s2;
        end
    end
    assign ram_rd_data = ram_s3;

    // Reference model.
    typedef struct {
        bit               id;
        int               left;
        logic [WIDTH-1:0] data;
    } rd_t;

    logic [WIDTH-1:0] m_mem [DEPTH];
    bit               m_run;
    int               m_init;
    bit               m_rr;
    rd_t              m_pend [$];
    logic [1:0]       m_rv;
    logic [WIDTH-1:0] m_rd [2];
    int               n_cmp, n_fail;

    function automatic void exp_grant(output bit g0, output bit g1, output bit cf);
        bit rd0, rd1;
        g0 = 0; g1 = 0; cf = 0;
        rd0 = (ben_0 == '0);
        rd1 = (ben_1 == '0);
        if (m_run && !stall) begin
            if (req_0 && req_1) begin
                if (rd0 != rd1) begin
                    g0 = 1; g1 = 1;
                end else begin
                    cf = 1;
                    if (m_rr) g1 = 1; else g0 = 1;
                end
            end else begin
                g0 = req_0; g1 = req_1;
            end
        end
    endfunction

    // Advance one clock: update the model from the inputs present at the edge.
    task automatic tick();
        bit g0, g1, cf;
        @(posedge clk);
        m_rv = 2'b00;
        if (!stall) begin
            if (!m_run) begin
                m_mem[m_init] = '0;
                if (m_init == DEPTH - 1) m_run = 1; else m_init++;
            end else begin
                exp_grant(g0, g1, cf);
                // Writes land before same-edge reads: matches byte forwarding.
                for (int b = 0; b < NB; b++) begin
                    if (g0 && ben_0[b]) m_mem[addr_0][b*8 +: 8] = wdata_0[b*8 +: 8];
                    if (g1 && ben_1[b]) m_mem[addr_1][b*8 +: 8] = wdata_1[b*8 +: 8];
                end
                if (g0 && ben_0 == '0) m_pend.push_back('{id: 1'b0, left: 3, data: m_mem[addr_0]});
                if (g1 && ben_1 == '0) m_pend.push_back('{id: 1'b1, left: 3, data: m_mem[addr_1]});
                if (cf) m_rr = !m_rr;
            end
            foreach (m_pend[i]) m_pend[i].left--;
            while (m_pend.size() > 0 && m_pend[0].left == 0) begin
                m_rv[m_pend[0].id] = 1'b1;
                m_rd[m_pend[0].id] = m_pend[0].data;
                void'(m_pend.pop_front());
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        stall = 0; req_0 = 0; req_1 = 0; ben_0 = '0; ben_1 = '0;
        addr_0 = '0; addr_1 = '0; wdata_0 = '0; wdata_1 = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        m_run = 0; m_init = 0; m_rr = 0; m_rv = 2'b00;
        m_pend.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        // A read held through zero-fill must be taken in cycle DEPTH.
        req_0 = 1; ben_0 = '0; addr_0 = 5;
        for (int c = 0; c < DEPTH; c++) begin
            #1;
            n_cmp++;
            if (ram_wr_en !== 4'hF || ram_wr_addr !== AW'(c) || ram_wr_data !== '0) begin
                n_fail++;
                $display("FAIL init_write c=%0d: got en=%h a=%0d d=%h want en=f a=%0d d=0",
                         c, ram_wr_en, ram_wr_addr, ram_wr_data, c);
            end
            n_cmp++;
            if ({ack_1, ack_0, init_done} !== 3'b000) begin
                n_fail++;
                $display("FAIL init_quiet c=%0d: got ack=%b%b done=%b want 000", c, ack_1, ack_0, init_done);
            end
            tick();
        end
        #1;
        n_cmp++;
        if (init_done !== 1'b1 || ack_0 !== 1'b1) begin
            n_fail++;
            $display("FAIL init_done: got done=%b ack0=%b want 1 1", init_done, ack_0);
        end
        tick();
        req_0 = 0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            n_cmp++;
            if (rvalid_0 !== (k == 3) || rvalid_1 !== 1'b0) begin
                n_fail++;
                $display("FAIL read_after_init k=%0d: got rv=%b%b want %b0", k, rvalid_0, rvalid_1, k == 3);
            end
            if (k == 3) begin
                n_cmp++;
                if (rdata_0 !== 32'h0) begin
                    n_fail++;
                    $display("FAIL read_after_init_data: got %h want 0", rdata_0);
                end
            end
            tick();
        end
    endtask

    task automatic test_dual_issue();
        req_0 = 1; ben_0 = 4'hF; addr_0 = 3; wdata_0 = 32'hDEADBEEF;
        req_1 = 1; ben_1 = '0; addr_1 = 3;
        #1;
        n_cmp++;
        if ({ack_0, ack_1} !== 2'b11 || ram_wr_en !== 4'hF || ram_wr_addr !== AW'(3)
            || ram_rd_addr !== AW'(3)) begin
            n_fail++;
            $display("FAIL dual_issue: got ack=%b%b en=%h wa=%0d ra=%0d want 11 f 3 3",
                     ack_0, ack_1, ram_wr_en, ram_wr_addr, ram_rd_addr);
        end
        tick();
        idle_inputs();
        for (int k = 1; k <= 4; k++) begin
            #1;
            n_cmp++;
            if (rvalid_1 !== (k == 3) || rvalid_0 !== 1'b0) begin
                n_fail++;
                $display("FAIL dual_rvalid k=%0d: got rv=%b%b want 0%b", k, rvalid_0, rvalid_1, k == 3);
            end
            if (k == 3) begin
                n_cmp++;
                if (rdata_1 !== 32'hDEADBEEF) begin
                    n_fail++;
                    $display("FAIL dual_data: got %h want deadbeef", rdata_1);
                end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        bit g0, g1, cf;
        // Distinct contents for addresses 1 and 2.
        req_1 = 1; ben_1 = 4'hF; addr_1 = 1; wdata_1 = 32'h0101_0101;
        tick();
        addr_1 = 2; wdata_1 = 32'hA5A5_0202;
        tick();
        req_0 = 1; ben_0 = '0; addr_0 = 1;
        req_1 = 1; ben_1 = '0; addr_1 = 2;
        for (int k = 0; k < 14; k++) begin
            if (k == 10) begin req_0 = 0; req_1 = 0; end
            #1;
            exp_grant(g0, g1, cf);
            n_cmp++;
            if (ack_0 !== g0 || ack_1 !== g1) begin
                n_fail++;
                $display("FAIL rr_ack k=%0d: got %b%b want %b%b", k, ack_0, ack_1, g0, g1);
            end
            if (k < 10) begin
                n_cmp++;
                if (ack_0 !== (k % 2 == 0)) begin
                    n_fail++;
                    $display("FAIL rr_alternate k=%0d: got ack0=%b want %b", k, ack_0, k % 2 == 0);
                end
            end
            n_cmp++;
            if ({rvalid_0, rvalid_1} !== {m_rv[0], m_rv[1]}
                || (m_rv[0] && rdata_0 !== m_rd[0]) || (m_rv[1] && rdata_1 !== m_rd[1])) begin
                n_fail++;
                $display("FAIL rr_return k=%0d: got rv=%b%b d=%h want rv=%b%b d0=%h d1=%h",
                         k, rvalid_0, rvalid_1, rdata_0, m_rv[0], m_rv[1], m_rd[0], m_rd[1]);
            end
            tick();
        end
    endtask

    task automatic test_stall();
        req_0 = 1; ben_0 = '0; addr_0 = 7;
        #1;
        n_cmp++;
        if (ack_0 !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_ack: got %b want 1", ack_0);
        end
        tick();
        req_0 = 0;
        for (int k = 1; k <= 9; k++) begin
            stall = (k <= 4);
            req_1 = (k <= 5); ben_1 = '0; addr_1 = 1;
            #1;
            n_cmp++;
            if (ram_clken !== !stall || ack_1 !== (k == 5)) begin
                n_fail++;
                $display("FAIL stall_ctl k=%0d: got clken=%b ack1=%b want %b %b",
                         k, ram_clken, ack_1, !stall, k == 5);
            end
            n_cmp++;
            if (rvalid_0 !== (k == 7) || rvalid_1 !== m_rv[1]) begin
                n_fail++;
                $display("FAIL stall_rvalid k=%0d: got %b%b want %b%b", k, rvalid_0, rvalid_1, k == 7, m_rv[1]);
            end
            if (k == 7) begin
                n_cmp++;
                if (rdata_0 !== 32'h0) begin
                    n_fail++;
                    $display("FAIL stall_data: got %h want 0", rdata_0);
                end
            end
            if (k == 8) begin
                n_cmp++;
                if (rdata_1 !== 32'h0101_0101) begin
                    n_fail++;
                    $display("FAIL stall_data1: got %h want 01010101", rdata_1);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_byte_write();
        req_0 = 1; ben_0 = 4'hF; addr_0 = 9; wdata_0 = 32'h11223344;
        tick();
        req_0 = 0;
        req_1 = 1; ben_1 = 4'h1; addr_1 = 9; wdata_1 = 32'h000000AA;
        tick();
        req_1 = 0;
        req_0 = 1; ben_0 = '0; addr_0 = 9;
        tick();
        req_0 = 0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            n_cmp++;
            if (rvalid_0 !== (k == 3)) begin
                n_fail++;
                $display("FAIL byte_rvalid k=%0d: got %b want %b", k, rvalid_0, k == 3);
            end
            if (k == 3) begin
                n_cmp++;
                if (rdata_0 !== 32'h112233AA) begin
                    n_fail++;
                    $display("FAIL byte_merge: got %h want 112233aa", rdata_0);
                end
            end
            tick();
        end
    endtask

    task automatic test_mid_reset();
        req_1 = 1; ben_1 = '0; addr_1 = 3;
        tick();
        req_1 = 0;
        rst = 1;
        #1;
        n_cmp++;
        if ({rvalid_0, rvalid_1, init_done, ack_0, ack_1} !== 5'b0
            || ram_wr_en !== 4'hF || ram_wr_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_now: got rv=%b%b done=%b en=%h a=%0d want 00 0 f 0",
                     rvalid_0, rvalid_1, init_done, ram_wr_en, ram_wr_addr);
        end
        do_reset();
        for (int c = 0; c < DEPTH; c++) begin
            #1;
            n_cmp++;
            if ({rvalid_0, rvalid_1} !== 2'b00 || ram_wr_addr !== AW'(c) || init_done !== 1'b0) begin
                n_fail++;
                $display("FAIL refill c=%0d: got rv=%b%b a=%0d done=%b want 00 %0d 0",
                         c, rvalid_0, rvalid_1, ram_wr_addr, init_done, c);
            end
            tick();
        end
        #1;
        n_cmp++;
        if (init_done !== 1'b1) begin
            n_fail++;
            $display("FAIL refill_done: got %b want 1", init_done);
        end
    endtask

    task automatic test_random();
        bit g0, g1, cf;
        for (int k = 0; k < 500; k++) begin
            if (k < 490) begin
                if (!req_0 && $urandom_range(0, 9) < 6) begin
                    req_0 = 1;
                    ben_0 = $urandom_range(0, 1) ? '0 : NB'($urandom_range(1, 15));
                    addr_0 = AW'($urandom_range(0, 7));
                    wdata_0 = $urandom;
                end
                if (!req_1 && $urandom_range(0, 9) < 6) begin
                    req_1 = 1;
                    ben_1 = $urandom_range(0, 1) ? '0 : NB'($urandom_range(1, 15));
                    addr_1 = AW'($urandom_range(0, 7));
                    wdata_1 = $urandom;
                end
                stall = ($urandom_range(0, 9) == 0);
            end else begin
                idle_inputs();
            end
            #1;
            exp_grant(g0, g1, cf);
            n_cmp++;
            if (ack_0 !== g0 || ack_1 !== g1) begin
                n_fail++;
                $display("FAIL rand_ack k=%0d: got %b%b want %b%b", k, ack_0, ack_1, g0, g1);
            end
            n_cmp++;
            if ({rvalid_0, rvalid_1} !== {m_rv[0], m_rv[1]}
                || (m_rv[0] && rdata_0 !== m_rd[0]) || (m_rv[1] && rdata_1 !== m_rd[1])) begin
                n_fail++;
                $display("FAIL rand_return k=%0d: got rv=%b%b d=%h want rv=%b%b d0=%h d1=%h",
                         k, rvalid_0, rvalid_1, rdata_0, m_rv[0], m_rv[1], m_rd[0], m_rd[1]);
            end
            tick();
            if (g0) req_0 = 0;
            if (g1) req_1 = 0;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1;
        idle_inputs();
        test_reset();
        test_dual_issue();
        test_back_to_back();
        test_stall();
        test_byte_write();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
